mag_mult_seq: RTL and testbench
===============================

Name: mag_mult_seq

Overview:
- Sequential sign-magnitude fixed-point multiplier core for the IIR datapath. It sits directly upstream of the output selector stage.
- Accepts two signed two's-complement Q15.16 operands over a valid/ready handshake and splits them into sign and magnitude.
- Runs a radix-2 shift-add multiply on the magnitudes and presents the unsigned 64-bit magnitude product plus sign and overflow flags.
- The output selector truncates, saturates and re-signs the result downstream; this block does none of that.

Parameters:
- OP_W, 32, operand width in bits (two's complement).
- FRAC_W, 16, fractional bits per operand; the output Q-point follows from it.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  OP_W  signed multiplicand, Q15.16.
- b  in  OP_W  signed multiplier, Q15.16.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  2*OP_W  unsigned magnitude product |a|*|b|, Q30.32.
- sign  out  1  sign of the true product.
- overflowHigh  out  1  magnitude does not fit the 31-bit Q15.16 output field.
- overflowShift  out  1  an operand was the most-negative value (-2^31).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - in_ready=1 after reset release; out_valid=0.
  - result=0, sign=0, overflowHigh=0, overflowShift=0.
  - Reset asserted mid-operation aborts immediately; the in-flight result is discarded and no out_valid is produced.
- FSM states: IDLE, RUN, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE: on in_valid&&in_ready (cycle N):
  - Register |a|, |b| as OP_W-bit unsigned. |-2^31| = 0x8000_0000 is representable.
  - Register sign_r = a[31]^b[31], forced to 0 if a==0 or b==0.
  - Register ovs_r = (a==0x8000_0000)||(b==0x8000_0000).
  - Clear the accumulator and the bit counter; go to RUN.
- RUN: one multiplier bit per cycle, LSB first.
  - If the multiplier LSB is 1, the accumulator adds the multiplicand shifted by the counter.
  - The multiplier shifts right and the counter increments.
  - After OP_W iterations, go to DONE. out_valid rises at cycle N+OP_W+1 (N+33 at default).
- DONE:
  - result = accumulator.
  - overflowHigh = |result[2*OP_W-1 : OP_W+FRAC_W-1], i.e. bits [63:47].
  - overflowShift = ovs_r; sign = sign_r.
  - All outputs stay stable while out_ready=0.
  - On out_ready=1: back to IDLE. in_ready returns next cycle; there is no same-cycle re-accept.
- Arithmetic: unsigned, full 2*OP_W width, no truncation or rounding inside this block.
- Boundaries:
  - in_valid held high with operands changing during RUN/DONE: ignored; only the values at the handshake are used.
  - out_ready high before DONE: no effect.
  - Both operands -2^31: result = 0x4000_0000_0000_0000, overflowHigh=1, overflowShift=1, sign=0.

Optional Feature:
- Macro: MAG_MULT_EARLY_TERM_EN.
- Defined: RUN exits to DONE on the cycle the remaining multiplier shift register becomes zero. Latency is 1 + index of the highest set bit of |b| + 1 cycles, minimum 2 (for b==0, DONE one cycle after the handshake). Results are identical.
- Undefined: fixed OP_W-cycle RUN.

Decomposition:
- Package iir_fix_pkg holds:
  - constants OP_W=32, FRAC_W=16, PROD_W=2*OP_W;
  - constant MIN_NEG=32'h8000_0000;
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
  - the index constant of the overflowHigh field (OP_W+FRAC_W-1).
- One sub-module, abs_split: combinational two's complement to {sign, magnitude}, instanced once per operand.

Test Plan:
- a=0x0001_8000 (1.5), b=0x0002_0000 (2.0) -> out_valid at handshake+33, result=0x0000_0003_0000_0000, sign=0, overflowHigh=0, overflowShift=0.
- a=0xFFFF_8000 (-0.5), b=0x0004_0000 (4.0) -> result=0x0000_0002_0000_0000, sign=1, both flags 0.
- a=0x7FFF_0000, b=0x0002_0000 -> result=0x0000_FFFE_0000_0000, overflowHigh=1, sign=0; a=0x8000_0000, b=0x0000_0001 -> result=0x8000_0000, overflowShift=1, sign=1.
- a=0x0000_0000, b=0xFFFF_0000 -> result=0, sign=0, flags 0. With MAG_MULT_EARLY_TERM_EN, b=0x0000_0001 -> out_valid at handshake+2.
- Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Raise out_ready -> out_valid=0 and in_ready=1 next cycle.
- Pulse rst_n low at handshake+10 -> out_valid=0, in_ready=1 after release. A following 1.5*2.0 gives the correct 0x3_0000_0000.

Source files
------------

// File: rtl/iir_fix_pkg.sv
// Shared fixed-point constants and state type for the IIR multiplier datapath.
// Q15.16 operands produce Q30.32 magnitude products.
package iir_fix_pkg;

  localparam int OP_W    = 32;
  localparam int FRAC_W  = 16;
  localparam int PROD_W  = 2 * OP_W;
  localparam logic [OP_W-1:0] MIN_NEG = 32'h8000_0000;
  // Lowest product bit that no longer fits the 31-bit Q15.16 output field.
  localparam int OVF_LSB = OP_W + FRAC_W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

endpackage

// File: rtl/mag_mult_seq_abs_split.sv
// Combinational two's complement to {sign, magnitude} split.
// The most-negative input maps to magnitude 2^(W-1), which fits unsigned.
module abs_split #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  output logic         neg,
  output logic [W-1:0] mag
);

  assign neg = value[W-1];
  assign mag = neg ? ('0 - value) : value;

endmodule

// File: rtl/mag_mult_seq.sv
// Sequential sign-magnitude shift-add multiplier producing |a|*|b| plus sign/overflow flags.
// Optional macro MAG_MULT_EARLY_TERM_EN: RUN ends once the remaining multiplier bits are zero.
module mag_mult_seq #(
  parameter int OP_W   = iir_fix_pkg::OP_W,
  parameter int FRAC_W = iir_fix_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*OP_W-1:0] result,
  output logic              sign,
  output logic              overflowHigh,
  output logic              overflowShift
);

  import iir_fix_pkg::*;

  localparam int PW    = 2 * OP_W;
  localparam int OVF_L = OP_W + FRAC_W - 1;
  localparam logic [OP_W-1:0] NEG_MIN = {1'b1, {(OP_W-1){1'b0}}};

  mult_state_t state, state_next;

  logic            a_neg, b_neg;
  logic [OP_W-1:0] a_mag, b_mag;
  logic [PW-1:0]   mcand;
  logic [OP_W-1:0] mplier;
  logic [PW-1:0]   acc;
  logic            sign_r;
  logic            ovs_r;
  logic            take;
  logic            last_iter;

  abs_split #(.W(OP_W)) u_abs_a (.value(a), .neg(a_neg), .mag(a_mag));
  abs_split #(.W(OP_W)) u_abs_b (.value(b), .neg(b_neg), .mag(b_mag));

  assign take = in_valid && (state == IDLE);

`ifdef MAG_MULT_EARLY_TERM_EN
  assign last_iter = (mplier >> 1) == '0;
`else
  localparam int CNT_W = $clog2(OP_W);
  logic [CNT_W-1:0] cnt;

  assign last_iter = (cnt == CNT_W'(OP_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The multiplicand register shifts left once per iteration, so it always
  // holds |a| shifted by the current bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_r <= 1'b0;
      ovs_r  <= 1'b0;
    end else if (take) begin
      mcand  <= PW'(a_mag);
      mplier <= b_mag;
      acc    <= '0;
      sign_r <= (a_neg ^ b_neg) && (a != '0) && (b != '0);
      ovs_r  <= (a == NEG_MIN) || (b == NEG_MIN);
    end else if (state == RUN) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign result        = acc;
  assign overflowHigh  = |acc[PW-1:OVF_L];
  assign overflowShift = ovs_r;
  assign sign          = sign_r;

endmodule

// File: tb/tb_mag_mult_seq.sv
// Self-checking bench for mag_mult_seq: directed vector table, random operands
// against an arithmetic reference, output hold, and mid-operation reset abort.
module tb_mag_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        sign;
  logic        overflowHigh;
  logic        overflowShift;

  int n_cmp = 0;
  int n_bad = 0;

  mag_mult_seq #(.OP_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a_in), .b(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sign(sign),
    .overflowHigh(overflowHigh), .overflowShift(overflowShift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        sgn;
    logic        ovh;
    logic        ovs;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [63:0] p, output logic s,
                                  output logic oh, output logic os);
    longint vx, vy, ax, ay;
    vx = longint'($signed(x));
    vy = longint'($signed(y));
    ax = (vx < 0) ? -vx : vx;
    ay = (vy < 0) ? -vy : vy;
    p  = 64'(ax * ay);
    s  = ((vx < 0) != (vy < 0)) && (vx != 0) && (vy != 0);
    oh = p >= 64'h0000_8000_0000_0000;
    os = (vx == -64'sd2147483648) || (vy == -64'sd2147483648);
  endfunction

  // Cycles from the handshake cycle to the first out_valid cycle.
  function automatic int ref_lat(input logic [31:0] y);
`ifdef MAG_MULT_EARLY_TERM_EN
    longint vy, t;
    int k;
    vy = longint'($signed(y));
    t  = (vy < 0) ? -vy : vy;
    if (t == 0) return 2;
    k = 0;
    while (t > 1) begin
      t = t / 2;
      k++;
    end
    return k + 2;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input string nm, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] e_res, input logic e_sgn, input logic e_ovh,
                        input logic e_ovs, input int hold);
    int  n;
    bit  got;
    int  lat;
    lat = ref_lat(y);
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    a_in      = x;
    b_in      = y;
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      a_in = $urandom;
      b_in = $urandom;
      @(posedge clk); #1;
      n++;
      chk({nm, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      if (out_valid) got = 1'b1;
      else out_ready = 1'($urandom_range(0, 1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({nm, "_latency"}, 64'(n + 1), 64'(lat));
    if (got) begin
      chk({nm, "_result"}, result, e_res);
      chk({nm, "_sign"}, 64'(sign), 64'(e_sgn));
      chk({nm, "_ovh"}, 64'(overflowHigh), 64'(e_ovh));
      chk({nm, "_ovs"}, 64'(overflowShift), 64'(e_ovs));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_hold_result"}, result, e_res);
        chk({nm, "_hold_flags"}, {61'd0, sign, overflowHigh, overflowShift},
            {61'd0, e_sgn, e_ovh, e_ovs});
        chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, "_drain_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_drain_in_ready"}, 64'(in_ready), 64'd1);
    end else begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  logic [63:0] r_res;
  logic        r_sgn, r_ovh, r_ovs;
  logic [31:0] ra, rb;
  bit          seen;

  initial begin
    tbl[0] = '{32'h0001_8000, 32'h0002_0000, 64'h0000_0003_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_8000, 32'h0004_0000, 64'h0000_0002_0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h7FFF_0000, 32'h0002_0000, 64'h0000_FFFE_0000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 64'h0000_0000_8000_0000, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{32'h0000_0000, 32'hFFFF_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_result", result, 64'd0);
    chk("reset_flags", {61'd0, sign, overflowHigh, overflowShift}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].res,
             tbl[i].sgn, tbl[i].ovh, tbl[i].ovs, (i == 0) ? 10 : 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       begin ra = $urandom; rb = $urandom_range(0, 255); end
        1:       begin ra = 32'h8000_0000; rb = $urandom; end
        2:       begin ra = $urandom; rb = '0; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      ref_mul(ra, rb, r_res, r_sgn, r_ovh, r_ovs);
      run_op($sformatf("rnd%0d", i), ra, rb, r_res, r_sgn, r_ovh, r_ovs,
             int'($urandom_range(0, 3)));
    end

    // Abort an operation in flight with an asynchronous reset pulse.
    @(negedge clk);
    a_in     = 32'h0001_8000;
    b_in     = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_op("after_abort", 32'h0001_8000, 32'h0002_0000, 64'h0000_0003_0000_0000,
           1'b0, 1'b0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
